// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 message sequencer:
//   - sha_seq_fsm_e : sequencer state encoding (also visible on dbg_state_o)
//   - WordSize      : stream word width in bits
//   - LenWidth      : width of the SHA-2 message bit-length field
//   - PadByte       : SHA-2 end-of-message marker byte
//   - pad_last_word : places the marker after the valid bytes of a final word
// -----------------------------------------------------------------------------
package sha256_pkg;

   localparam int         WordSize = 32;
   localparam int         LenWidth = 64;
   localparam logic [7:0] PadByte  = 8'h80;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      CLR   = 4'd1,
      FILL  = 4'd2,
      PAD2  = 4'd3,
      LEN   = 4'd4,
      ISSUE = 4'd5,
      WAIT  = 4'd6,
      DONE  = 4'd7,
      ERROR = 4'd8
   } sha_seq_fsm_e;

   // Keeps the first n bytes (big-endian), puts the marker in byte n and
   // zeroes the rest. With n = 4 the word is returned unchanged; the marker
   // then belongs to the following word.
   function automatic logic [WordSize-1:0] pad_last_word(
      input logic [WordSize-1:0] d,
      input logic [2:0]          n
   );
      logic [WordSize-1:0] w;
      case (n)
         3'd0:    w = {PadByte, 24'h0};
         3'd1:    w = {d[31:24], PadByte, 16'h0};
         3'd2:    w = {d[31:16], PadByte, 8'h0};
         3'd3:    w = {d[31:8], PadByte};
         default: w = d;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/sha256_block_buffer.sv
// -----------------------------------------------------------------------------
// sha256_block_buffer
// 16 x 32-bit block store feeding the SHA-256 core.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset (buffer cleared)
//   i_clr          : zero the whole buffer
//   i_clr_marker   : with i_clr, place the marker word in word 0 (spilled pad)
//   i_wr           : write i_data at word i_idx
//   i_last         : the written word is the message's last; insert marker
//   i_bytes        : valid bytes of the written word
//   i_len_wr       : write i_len into words 14..15
//   o_block        : packed block, word 0 in [511:480]
// Operations are mutually exclusive by construction in the sequencer; the
// priority below only matters for robustness.
// -----------------------------------------------------------------------------
module sha256_block_buffer
   import sha256_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_clr,
   input  logic                i_clr_marker,
   input  logic                i_wr,
   input  logic [3:0]          i_idx,
   input  logic [WordSize-1:0] i_data,
   input  logic [2:0]          i_bytes,
   input  logic                i_last,
   input  logic                i_len_wr,
   input  logic [LenWidth-1:0] i_len,
   output logic [511:0]        o_block
);

   logic [WordSize-1:0] r_words [16];

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         for (int i = 0; i < 16; i++) r_words[i] <= '0;
         if (!i_rst && i_clr_marker) r_words[0] <= {PadByte, 24'h0};
      end else if (i_len_wr) begin
         r_words[14] <= i_len[63:32];
         r_words[15] <= i_len[31:0];
      end else if (i_wr) begin
         if (i_last) begin
            r_words[i_idx] <= pad_last_word(i_data, i_bytes);
            // A full final word pushes the marker into the next word; at
            // word 15 it spills into the next block instead (i_clr_marker).
            if (i_bytes == 3'd4 && i_idx != 4'd15)
               r_words[i_idx + 4'd1] <= {PadByte, 24'h0};
         end else begin
            r_words[i_idx] <= i_data;
         end
      end
   end

   for (genvar g = 0; g < 16; g++) begin : g_pack
      assign o_block[511-32*g -: 32] = r_words[g];
   end

endmodule

// File: rtl/sha256_sequencer.sv
// -----------------------------------------------------------------------------
// sha256_sequencer
// Message-level controller for one sha256_core: assembles 512-bit blocks from
// a 32-bit big-endian word stream, applies SHA-2 padding and chains blocks.
// Optional feature: define SHA_SEQ_WATCHDOG_EN to add a per-block watchdog
// (TimeoutCycles cycles in ISSUE/WAIT without a completion event -> ERROR).
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   start_i                 : abort and begin a new message (highest priority)
//   data_i/data_bytes_i/data_last_i/data_valid_i/data_ready_o : word stream
//   core_block_o, core_enable_o, core_rst_o : to core
//   core_hold_i, core_idle_i, core_digest_i, core_digest_valid_i : from core
//   digest_o, digest_valid_o: final digest, valid sticky until start/reset
//   busy_o, err_o           : status
//   dbg_state_o             : current FSM state (sha_seq_fsm_e encoding)
// Handshake: a word transfers on a rising clk edge where data_valid_i and
// data_ready_o are both high and start_i is low; data_ready_o depends on state
// only, so the source may hold valid high across block boundaries.
// -----------------------------------------------------------------------------
module sha256_sequencer
   import sha256_pkg::*;
#(
   parameter int BlockWidth    = 512,
   parameter int DigestWidth   = 256,
   parameter int TimeoutCycles = 96
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [WordSize-1:0]    data_i,
   input  logic [2:0]             data_bytes_i,
   input  logic                   data_last_i,
   input  logic                   data_valid_i,
   output logic                   data_ready_o,
   output logic [BlockWidth-1:0]  core_block_o,
   output logic                   core_enable_o,
   output logic                   core_rst_o,
   input  logic                   core_hold_i,
   input  logic                   core_idle_i,
   input  logic [DigestWidth-1:0] core_digest_i,
   input  logic                   core_digest_valid_i,
   output logic [DigestWidth-1:0] digest_o,
   output logic                   digest_valid_o,
   output logic                   busy_o,
   output logic                   err_o,
   output logic [3:0]             dbg_state_o
);

   sha_seq_fsm_e         r_state;
   logic [LenWidth-1:0]  r_byte_cnt;
   logic [3:0]           r_idx;
   logic                 r_final;     // block in flight is the last one
   logic                 r_pad2_pend; // a padding-only block must follow
   logic                 r_spill;     // that block starts with the marker
   logic                 r_seen;      // core has visibly started this block
   logic [DigestWidth-1:0] r_digest;

   logic w_accept, w_bad_bytes, w_wr, w_marker_late;
   logic w_clr, w_clr_marker, w_len_wr;
   logic w_evt_next, w_evt_done, w_evt_err, w_timeout;
   logic [511:0] w_block;

   assign w_accept    = (r_state == FILL) && data_valid_i && !start_i;
   assign w_bad_bytes = (data_bytes_i > 3'd4) || (data_bytes_i == 3'd0 && !data_last_i);
   assign w_wr        = w_accept && !w_bad_bytes;

   // Marker in word 14/15 (or spilled past 15) leaves no room for the length.
   assign w_marker_late = (data_bytes_i == 3'd4) ? (r_idx >= 4'd13) : (r_idx >= 4'd14);

   assign w_evt_next = (r_state == WAIT) && r_seen && !r_final && core_hold_i;
   assign w_evt_done = (r_state == WAIT) && r_seen && r_final && core_digest_valid_i;
   assign w_evt_err  = (r_state == WAIT) && r_seen &&
                       ((!r_final && !core_hold_i && core_digest_valid_i) ||
                        (r_final && !core_digest_valid_i && core_hold_i));

   assign w_clr        = (r_state == CLR) || (r_state == PAD2) || w_evt_next;
   assign w_clr_marker = (r_state == PAD2) && r_spill;
   assign w_len_wr     = (r_state == LEN) && !start_i;

`ifdef SHA_SEQ_WATCHDOG_EN
   localparam int WdW = $clog2(TimeoutCycles + 1);
   logic [WdW-1:0] r_wd_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i || start_i || !(r_state == ISSUE || r_state == WAIT))
         r_wd_cnt <= '0;
      else
         r_wd_cnt <= r_wd_cnt + 1'b1;
   end

   assign w_timeout = (r_state == WAIT) && (r_wd_cnt == WdW'(TimeoutCycles - 1));
`else
   assign w_timeout = 1'b0;
`endif

   sha256_block_buffer u_buf (
      .i_clk        (clk_i),
      .i_rst        (rst_i),
      .i_clr        (w_clr),
      .i_clr_marker (w_clr_marker),
      .i_wr         (w_wr),
      .i_idx        (r_idx),
      .i_data       (data_i),
      .i_bytes      (data_bytes_i),
      .i_last       (data_last_i),
      .i_len_wr     (w_len_wr),
      .i_len        ({r_byte_cnt[LenWidth-4:0], 3'b000}),
      .o_block      (w_block)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_byte_cnt  <= '0;
         r_idx       <= '0;
         r_final     <= 1'b0;
         r_pad2_pend <= 1'b0;
         r_spill     <= 1'b0;
         r_seen      <= 1'b0;
         r_digest    <= '0;
      end else if (start_i) begin
         r_state     <= CLR;
         r_final     <= 1'b0;
         r_pad2_pend <= 1'b0;
         r_spill     <= 1'b0;
         r_seen      <= 1'b0;
      end else begin
         case (r_state)
            CLR: begin
               r_byte_cnt <= '0;
               r_idx      <= '0;
               if (core_idle_i) r_state <= FILL;
            end
            FILL: begin
               if (data_valid_i) begin
                  if (w_bad_bytes) begin
                     r_state <= ERROR;
                  end else begin
                     r_byte_cnt <= r_byte_cnt + LenWidth'(data_bytes_i);
                     if (!data_last_i) begin
                        if (r_idx == 4'd15) begin
                           r_final <= 1'b0;
                           r_state <= ISSUE;
                        end
                        r_idx <= r_idx + 4'd1;
                     end else if (w_marker_late) begin
                        r_final     <= 1'b0;
                        r_pad2_pend <= 1'b1;
                        r_spill     <= (data_bytes_i == 3'd4) && (r_idx == 4'd15);
                        r_state     <= ISSUE;
                     end else begin
                        r_state <= LEN;
                     end
                  end
               end
            end
            PAD2: begin
               r_pad2_pend <= 1'b0;
               r_spill     <= 1'b0;
               r_state     <= LEN;
            end
            LEN: begin
               r_final <= 1'b1;
               r_state <= ISSUE;
            end
            ISSUE: begin
               r_seen  <= 1'b0;
               r_state <= WAIT;
            end
            WAIT: begin
               if (!core_hold_i && !core_idle_i) r_seen <= 1'b1;
               if (w_evt_next) begin
                  r_idx   <= '0;
                  r_state <= r_pad2_pend ? PAD2 : FILL;
               end else if (w_evt_done) begin
                  r_digest <= core_digest_i;
                  r_state  <= DONE;
               end else if (w_evt_err || w_timeout) begin
                  r_state <= ERROR;
               end
            end
            default: ;
         endcase
      end
   end

   assign data_ready_o   = (r_state == FILL);
   assign core_enable_o  = (r_state == ISSUE) || (r_state == WAIT);
   assign core_rst_o     = (r_state == IDLE) || (r_state == CLR) || (r_state == ERROR);
   assign core_block_o   = w_block;
   assign digest_o       = r_digest;
   assign digest_valid_o = (r_state == DONE);
   assign err_o          = (r_state == ERROR);
   assign busy_o         = !((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
   assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_sha256_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sha256_sequencer
// Drives byte messages through sha256_sequencer against a behavioural SHA-256
// core. Expected padded blocks and digests are built from the message bytes
// and queued when a message is sent; they are popped when the core starts a
// block and when digest_valid_o rises.
// -----------------------------------------------------------------------------
module tb_sha256_sequencer;

   localparam int LAT = 64;
   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] DIG_56    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_i, start_i, data_last_i, data_valid_i, data_ready_o;
   logic [31:0]  data_i;
   logic [2:0]   data_bytes_i;
   logic [511:0] core_block_o;
   logic         core_enable_o, core_rst_o, core_hold_i, core_idle_i, core_digest_valid_i;
   logic [255:0] core_digest_i, digest_o;
   logic         digest_valid_o, busy_o, err_o;
   logic [3:0]   dbg_state;

   sha256_sequencer dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
      .data_i(data_i), .data_bytes_i(data_bytes_i), .data_last_i(data_last_i),
      .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
      .core_block_o(core_block_o), .core_enable_o(core_enable_o), .core_rst_o(core_rst_o),
      .core_hold_i(core_hold_i), .core_idle_i(core_idle_i), .core_digest_i(core_digest_i),
      .core_digest_valid_i(core_digest_valid_i), .digest_o(digest_o),
      .digest_valid_o(digest_valid_o), .busy_o(busy_o), .err_o(err_o),
      .dbg_state_o(dbg_state)
   );

   // ---------------- SHA-256 reference ----------------
   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_compress(input logic [255:0] h_in, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 64; i++)
         w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) +
                w[i-7] + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
      {a, b, c, d, e, f, g, h} = h_in;
      for (int i = 0; i < 64; i++) begin
         t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[i] + w[i];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {h_in[255:224] + a, h_in[223:192] + b, h_in[191:160] + c, h_in[159:128] + d,
              h_in[127:96] + e, h_in[95:64] + f, h_in[63:32] + g, h_in[31:0] + h};
   endfunction

   // ---------------- behavioural core ----------------
   // Starts a block on a rising enable; after LAT cycles raises hold and
   // digest-valid together until the next block starts.
   logic         m_busy = 1'b0, m_hold = 1'b0, m_prev_en = 1'b0, m_stuck = 1'b0;
   int           m_cnt = 0;
   logic [255:0] m_h = IV;
   logic [511:0] m_blk = '0;

   always @(posedge clk) begin
      m_prev_en <= core_enable_o;
      if (core_rst_o === 1'b1) begin
         m_busy <= 1'b0; m_hold <= 1'b0; m_h <= IV;
      end else if (core_enable_o && !m_prev_en && !m_busy) begin
         m_busy <= 1'b1; m_hold <= 1'b0; m_blk <= core_block_o; m_cnt <= 0;
      end else if (m_busy && !m_stuck) begin
         if (m_cnt == LAT - 1) begin
            m_busy <= 1'b0; m_hold <= 1'b1; m_h <= sha_compress(m_h, m_blk);
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   assign core_idle_i         = !m_busy && !m_hold;
   assign core_hold_i         = m_hold;
   assign core_digest_valid_i = m_hold;
   assign core_digest_i       = m_h;

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [511:0] exp_blk_q[$];
   logic [255:0] exp_dig_q[$];
   logic [7:0]   msg[$];

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic mon_prev_en = 1'b0, mon_prev_dv = 1'b0;
   always @(negedge clk) begin
      if (core_enable_o === 1'b1 && !mon_prev_en) begin
         check("blk_expected", exp_blk_q.size() != 0, 1'b1);
         if (exp_blk_q.size() != 0) check("block", core_block_o, exp_blk_q.pop_front());
      end
      if (digest_valid_o === 1'b1 && !mon_prev_dv) begin
         check("dig_expected", exp_dig_q.size() != 0, 1'b1);
         if (exp_dig_q.size() != 0) check("digest", digest_o, exp_dig_q.pop_front());
      end
      mon_prev_en <= (core_enable_o === 1'b1);
      mon_prev_dv <= (digest_valid_o === 1'b1);
   end

   // Standard byte-oriented SHA-2 padding of msg; queues blocks and digest.
   task automatic push_expected(input logic [255:0] dig_const, input bit use_const, input bit push_dig);
      logic [7:0]   pb[$];
      logic [63:0]  bit_len;
      logic [511:0] blk;
      logic [255:0] h;
      pb = msg;
      bit_len = 64'(msg.size()) * 64'd8;
      pb.push_back(8'h80);
      while (pb.size() % 64 != 56) pb.push_back(8'h00);
      for (int k = 7; k >= 0; k--) pb.push_back(bit_len[8*k +: 8]);
      h = IV;
      for (int b = 0; b < pb.size() / 64; b++) begin
         for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pb[64*b+j];
         exp_blk_q.push_back(blk);
         h = sha_compress(h, blk);
      end
      if (push_dig) exp_dig_q.push_back(use_const ? dig_const : h);
   endtask

   // ---------------- drivers ----------------
   task automatic start_pulse();
      @(negedge clk); start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
      int waited;
      data_i = d; data_bytes_i = nb; data_last_i = last; data_valid_i = 1'b1;
      waited = 0;
      while (!data_ready_o && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      check("ready_wait", waited < 1000, 1'b1);
      @(negedge clk);
   endtask

   task automatic send_msg();
      int n, nw, nb;
      logic [31:0] d;
      n  = msg.size();
      nw = (n == 0) ? 1 : (n + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         d  = '0;
         nb = n - 4 * w;
         if (nb > 4) nb = 4;
         for (int j = 0; j < nb; j++) d[31-8*j -: 8] = msg[4*w+j];
         send_word(d, 3'(nb), w == nw - 1);
      end
      data_valid_i = 1'b0;
      data_last_i  = 1'b0;
   endtask

   task automatic wait_end();
      int cyc;
      cyc = 0;
      while (!(digest_valid_o || err_o) && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      check("done_wait", cyc < 1000, 1'b1);
      check("done_dv", digest_valid_o, 1'b1);
      check("done_busy", busy_o, 1'b0);
      check("done_err", err_o, 1'b0);
   endtask

   task automatic run_msg(input logic [255:0] dig_const, input bit use_const);
      start_pulse();
      check("start_dv_clr", digest_valid_o, 1'b0);
      push_expected(dig_const, use_const, 1'b1);
      send_msg();
      wait_end();
   endtask

   task automatic load_string(input string s);
      msg.delete();
      for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
   endtask

   task automatic load_random(input int n);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int lens [4];
      lens = '{55, 61, 64, 72};
      rst_i = 1'b1; start_i = 1'b0; data_i = '0; data_bytes_i = '0;
      data_last_i = 1'b0; data_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", data_ready_o, 1'b0);
      check("rst_enable", core_enable_o, 1'b0);
      check("rst_dv", digest_valid_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_err", err_o, 1'b0);
      check("rst_core_rst", core_rst_o, 1'b1);
      check("rst_block", core_block_o, '0);
      check("rst_digest", digest_o, '0);
      check("rst_state", dbg_state, 4'd0);
      rst_i = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_core_rst", core_rst_o, 1'b1);

      // Known vectors: digests are the published SHA-256 values.
      load_string("abc");
      run_msg(DIG_ABC, 1'b1);
      msg.delete();
      run_msg(DIG_EMPTY, 1'b1);
      load_string("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
      run_msg(DIG_56, 1'b1);

      // Padding boundaries; 72 bytes keeps valid high across the first block.
      foreach (lens[i]) begin
         load_random(lens[i]);
         run_msg('0, 1'b0);
      end

      // Abort mid-FILL, then a clean message.
      start_pulse();
      check("abort_dv", digest_valid_o, 1'b0);
      check("abort_core_rst", core_rst_o, 1'b1);
      for (int i = 0; i < 5; i++) send_word($urandom, 3'd4, 1'b0);
      data_valid_i = 1'b0;
      start_pulse();
      check("abort2_core_rst", core_rst_o, 1'b1);
      check("abort2_busy", busy_o, 1'b1);
      load_string("abc");
      push_expected(DIG_ABC, 1'b1, 1'b1);
      send_msg();
      wait_end();

      // Protocol violation: zero-byte word that is not the last.
      start_pulse();
      send_word(32'h12345678, 3'd0, 1'b0);
      data_valid_i = 1'b0;
      check("proto_err", err_o, 1'b1);
      check("proto_busy", busy_o, 1'b0);
      check("proto_core_rst", core_rst_o, 1'b1);
      start_pulse();
      check("proto_err_clr", err_o, 1'b0);

      // Core that never completes.
      m_stuck = 1'b1;
      start_pulse();
      load_string("abc");
      push_expected('0, 1'b0, 1'b0);
      send_msg();
      repeat (150) @(negedge clk);
`ifdef SHA_SEQ_WATCHDOG_EN
      check("stuck_err", err_o, 1'b1);
      check("stuck_busy", busy_o, 1'b0);
`else
      check("stuck_busy", busy_o, 1'b1);
      check("stuck_err", err_o, 1'b0);
`endif
      m_stuck = 1'b0;
      start_pulse();
      repeat (3) @(negedge clk);
      check("blk_q_left", exp_blk_q.size(), 0);
      check("dig_q_left", exp_dig_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
